// File: rtl/dsm_sample_ctrl.sv
// Sample scheduler/sequencer for the delta-sigma modulator: sample FIFO, OSR pacing,
// modulator reset and soft-start/stop gain ramp. Optional dither: DSM_SAMPLE_CTRL_DITHER_EN.
module dsm_sample_ctrl #(
  parameter int T_BITS     = 15,
  parameter int OSR        = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int RAMP_SHIFT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              clr_underrun,
  input  logic              s_valid,
  input  logic [T_BITS-1:0] s_data,
  output logic              s_ready,
  output logic [T_BITS-1:0] vin,
  output logic [T_BITS-6:0] dith,
  output logic              dsm_reset,
  output logic [1:0]        state,
  output logic              underrun
);

  typedef enum logic [1:0] {IDLE = 2'd0, RAMP = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_t;

  localparam int TICK_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int PW     = T_BITS + RAMP_SHIFT + 1;

  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(OSR - 1);
  localparam logic [CNT_W-1:0]    CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [RAMP_SHIFT:0] GAIN_FULL = {1'b1, {RAMP_SHIFT{1'b0}}};
  localparam logic [RAMP_SHIFT:0] GAIN_ONE  = {{RAMP_SHIFT{1'b0}}, 1'b1};

  state_t                    state_q, state_d;
  logic [TICK_W-1:0]         tick_q;
  logic [RAMP_SHIFT:0]       gain_q, gain_d;
  logic signed [T_BITS-1:0]  held_q;
  logic [T_BITS-1:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]          count_q;
  logic [T_BITS-1:0]         vin_d;
  logic                      tick_end, fetch, fifo_empty, push, pop, flush, underrun_set;

  assign tick_end   = (tick_q == TICK_LAST);
  assign fifo_empty = (count_q == '0);
  assign s_ready    = (count_q != CNT_FULL) && (state_q != DRAIN);
  assign push       = s_valid && s_ready;
  assign pop        = fetch && !fifo_empty;
  assign flush      = (state_q != IDLE) && (state_d == IDLE);
  assign underrun_set = fetch && fifo_empty && (state_q == RAMP || state_q == RUN);
  assign state      = state_q;

  // NOTE: every variable written here gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    fetch   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RAMP;
          gain_d  = GAIN_ONE;
          fetch   = 1'b1;
        end
      end
      RAMP: begin
        fetch = tick_end;
        if (!enable) begin
          state_d = DRAIN;
        end else if (tick_end) begin
          // A ramp resumed from DRAIN may start at full gain; clamp instead of overshooting.
          if (gain_q >= GAIN_FULL - 1'b1) begin
            gain_d  = GAIN_FULL;
            state_d = RUN;
          end else begin
            gain_d = gain_q + 1'b1;
          end
        end
      end
      RUN: begin
        fetch = tick_end;
        if (!enable) state_d = DRAIN;
      end
      DRAIN: begin
        fetch = tick_end;
        if (enable) begin
          state_d = RAMP;
        end else if (tick_end) begin
          gain_d = gain_q - 1'b1;
          if (gain_q == GAIN_ONE) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Signed product is wide enough for full-scale negative input at full gain.
  always_comb begin
    vin_d = T_BITS'((PW'(held_q) * PW'($signed({1'b0, gain_q}))) >>> RAMP_SHIFT);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      gain_q    <= '0;
      held_q    <= '0;
      vin       <= '0;
      dsm_reset <= 1'b1;
      underrun  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      gain_q    <= gain_d;
      vin       <= vin_d;
      dsm_reset <= (state_d == IDLE);
      if (state_q == IDLE || tick_end) tick_q <= '0;
      else                             tick_q <= tick_q + 1'b1;
      if (underrun_set)      underrun <= 1'b1;
      else if (clr_underrun) underrun <= 1'b0;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        held_q   <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
          held_q   <= mem[rd_ptr_q];
        end
        if (push && !pop)      count_q <= count_q + 1'b1;
        else if (pop && !push) count_q <= count_q - 1'b1;
      end
    end
  end

  // NOTE: FIFO storage has no reset; the count and pointers alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= s_data;
  end

`ifdef DSM_SAMPLE_CTRL_DITHER_EN
  logic [15:0] lfsr_q;

  // Galois LFSR, x^16+x^14+x^13+x^11+1, shifting right.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= 16'hACE1;
      dith   <= '0;
    end else begin
      if (state_q != IDLE)
        lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      if (state_q == IDLE) dith <= '0;
      else                 dith <= {{(T_BITS-9){lfsr_q[3]}}, lfsr_q[3:0]};
    end
  end
`else
  assign dith = '0;
`endif

endmodule

// File: tb/tb_dsm_sample_ctrl.sv
// Directed self-checking bench for dsm_sample_ctrl with OSR=4, RAMP_SHIFT=2, FIFO_DEPTH=4.
module tb_dsm_sample_ctrl;

  logic        clock = 1'b0;
  logic        reset_n, enable, clr_underrun, s_valid;
  logic [14:0] s_data;
  logic        s_ready, dsm_reset, underrun;
  logic [14:0] vin;
  logic [9:0]  dith;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  dsm_sample_ctrl #(.T_BITS(15), .OSR(4), .FIFO_DEPTH(4), .RAMP_SHIFT(2)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .clr_underrun(clr_underrun),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .vin(vin), .dith(dith),
    .dsm_reset(dsm_reset), .state(state), .underrun(underrun)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [14:0] d);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) begin
      checks++; errors++;
      $display("FAIL push_timeout s_ready=%0b required=1", s_ready);
    end
    tick();
    s_valid = 1'b0;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; clr_underrun = 1'b0; s_valid = 1'b0; s_data = '0;
    ticks(2);
    checks++; if (vin !== 15'd0) begin errors++; $display("FAIL reset_vin got=%0d want=0", vin); end
    checks++; if (dith !== 10'd0) begin errors++; $display("FAIL reset_dith got=%0d want=0", dith); end
    checks++; if (dsm_reset !== 1'b1) begin errors++; $display("FAIL reset_dsm_reset got=%0b want=1", dsm_reset); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", state); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got=%0b want=0", underrun); end
    reset_n = 1'b1;
    tick();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got=%0b want=1", s_ready); end
  endtask

  task automatic test_ramp();
    push(15'd1000); push(15'd2000); push(15'd3000);
    enable = 1'b1; s_valid = 1'b1; s_data = 15'd4000;
    tick(); // e1
    s_valid = 1'b0;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL ramp_e1_state got=%0d want=1", state); end
    checks++; if (dsm_reset !== 1'b0) begin errors++; $display("FAIL ramp_e1_dsm_reset got=%0b want=0", dsm_reset); end
    checks++; if (vin !== 15'd0) begin errors++; $display("FAIL ramp_e1_vin got=%0d want=0", $signed(vin)); end
    tick(); // e2
    checks++; if (vin !== 15'd250) begin errors++; $display("FAIL ramp_g1_vin got=%0d want=250", $signed(vin)); end
    ticks(3); // e5
    checks++; if (vin !== 15'd250) begin errors++; $display("FAIL ramp_g1_hold_vin got=%0d want=250", $signed(vin)); end
    tick(); // e6
    checks++; if (vin !== 15'd1000) begin errors++; $display("FAIL ramp_g2_vin got=%0d want=1000", $signed(vin)); end
    ticks(4); // e10
    checks++; if (vin !== 15'd2250) begin errors++; $display("FAIL ramp_g3_vin got=%0d want=2250", $signed(vin)); end
    ticks(2); // e12
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL ramp_e12_state got=%0d want=1", state); end
    tick(); // e13
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL ramp_run_state got=%0d want=2", state); end
    tick(); // e14
    checks++; if (vin !== 15'd4000) begin errors++; $display("FAIL run_g4_vin got=%0d want=4000", $signed(vin)); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ramp_underrun got=%0b want=0", underrun); end
  endtask

  task automatic test_full_scale();
    s_valid = 1'b1; s_data = 15'(-16384);
    tick(); // e15
    s_data = 15'd500;
    tick(); // e16
    s_valid = 1'b0;
    tick(); // e17
    checks++; if (vin !== 15'd4000) begin errors++; $display("FAIL fs_pre_vin got=%0d want=4000", $signed(vin)); end
    for (int i = 0; i < 4; i++) begin
      tick(); // e18..e21
      checks++; if (vin !== 15'(-16384)) begin errors++; $display("FAIL fs_neg_vin[%0d] got=%0d want=-16384", i, $signed(vin)); end
    end
    tick(); // e22
    checks++; if (vin !== 15'd500) begin errors++; $display("FAIL fs_next_vin got=%0d want=500", $signed(vin)); end
  endtask

  task automatic test_underrun();
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_before got=%0b want=0", underrun); end
    ticks(3); // e25 fetch with empty FIFO
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_set got=%0b want=1", underrun); end
    tick(); // e26
    checks++; if (vin !== 15'd500) begin errors++; $display("FAIL ur_hold_vin got=%0d want=500", $signed(vin)); end
    clr_underrun = 1'b1;
    tick(); // e27
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_clear got=%0b want=0", underrun); end
    ticks(2); // e29 set and clear together
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_set_wins got=%0b want=1", underrun); end
  endtask

  task automatic test_drain_from_run();
    enable = 1'b0; clr_underrun = 1'b1;
    tick(); // e30
    clr_underrun = 1'b0;
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL drn_state got=%0d want=3", state); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL drn_s_ready got=%0b want=0", s_ready); end
    ticks(4); // e34
    checks++; if (vin !== 15'd375) begin errors++; $display("FAIL drn_g3_vin got=%0d want=375", $signed(vin)); end
    ticks(4); // e38
    checks++; if (vin !== 15'd250) begin errors++; $display("FAIL drn_g2_vin got=%0d want=250", $signed(vin)); end
    ticks(4); // e42
    checks++; if (vin !== 15'd125) begin errors++; $display("FAIL drn_g1_vin got=%0d want=125", $signed(vin)); end
    ticks(2); // e44
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL drn_e44_state got=%0d want=3", state); end
    tick(); // e45
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL drn_idle_state got=%0d want=0", state); end
    checks++; if (dsm_reset !== 1'b1) begin errors++; $display("FAIL drn_dsm_reset got=%0b want=1", dsm_reset); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL drn_no_underrun got=%0b want=0", underrun); end
    tick(); // e46
    checks++; if (vin !== 15'd0) begin errors++; $display("FAIL drn_idle_vin got=%0d want=0", $signed(vin)); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL drn_idle_s_ready got=%0b want=1", s_ready); end
  endtask

  task automatic test_drain_from_ramp();
    push(15'd800); push(15'd1200); push(15'd1600); push(15'd2000);
    enable = 1'b1;
    tick(); // e1
    s_valid = 1'b1; s_data = 15'd2400;
    tick(); // e2
    s_valid = 1'b0;
    ticks(4); // e6
    checks++; if (vin !== 15'd600) begin errors++; $display("FAIL rdr_g2_vin got=%0d want=600", $signed(vin)); end
    enable = 1'b0;
    tick(); // e7
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL rdr_state got=%0d want=3", state); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rdr_s_ready_e7 got=%0b want=0", s_ready); end
    for (int i = 0; i < 5; i++) begin
      tick(); // e8..e12
      checks++; if (s_ready !== 1'b0 || state !== 2'd3) begin
        errors++; $display("FAIL rdr_drain[%0d] s_ready=%0b state=%0d want 0/3", i, s_ready, state);
      end
    end
    checks++; if (vin !== 15'd400) begin errors++; $display("FAIL rdr_g1_vin got=%0d want=400", $signed(vin)); end
    tick(); // e13
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rdr_idle got=%0d want=0", state); end
    checks++; if (dsm_reset !== 1'b1) begin errors++; $display("FAIL rdr_dsm_reset got=%0b want=1", dsm_reset); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rdr_idle_s_ready got=%0b want=1", s_ready); end
  endtask

  // Also proves the flush: a leftover 2400 would show up as vin=600 at the first ramp step.
  task automatic test_fill_full();
    s_valid = 1'b1;
    s_data = 15'(-10); tick();
    s_data = 15'd20;   tick();
    s_data = 15'd30;   tick();
    s_data = 15'd40;   tick();
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_s_ready got=%0b want=0", s_ready); end
    s_data = 15'd50;
    ticks(2);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_hold_s_ready got=%0b want=0", s_ready); end
    enable = 1'b1;
    tick(); // e1 pop frees a slot
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop got=%0b want=1", s_ready); end
    tick(); // e2 fifth sample accepted
    s_valid = 1'b0;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_refull got=%0b want=0", s_ready); end
    checks++; if (vin !== 15'(-3)) begin errors++; $display("FAIL full_floor_vin got=%0d want=-3", $signed(vin)); end
    ticks(4); // e6
    checks++; if (vin !== 15'd10) begin errors++; $display("FAIL full_s2_vin got=%0d want=10", $signed(vin)); end
    ticks(4); // e10
    checks++; if (vin !== 15'd22) begin errors++; $display("FAIL full_s3_vin got=%0d want=22", $signed(vin)); end
    ticks(4); // e14
    checks++; if (vin !== 15'd40 || state !== 2'd2) begin
      errors++; $display("FAIL full_s4 vin=%0d state=%0d want 40/2", $signed(vin), state);
    end
    ticks(4); // e18
    checks++; if (vin !== 15'd50) begin errors++; $display("FAIL full_s5_vin got=%0d want=50", $signed(vin)); end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] l;
    logic [9:0]  exp_dith;
    s_valid = 1'b1; s_data = 15'd7000;
    tick();
    s_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (vin !== 15'd0 || dith !== 10'd0 || dsm_reset !== 1'b1 || state !== 2'd0 ||
                  underrun !== 1'b0 || s_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset vin=%0d dith=%0d dsm_reset=%0b state=%0d underrun=%0b s_ready=%0b",
                         $signed(vin), dith, dsm_reset, state, underrun, s_ready);
    end
    enable = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    push(15'd400);
    enable = 1'b1;
    tick(); // e1
    checks++; if (dith !== 10'd0) begin errors++; $display("FAIL rst_e1_dith got=%0d want=0", dith); end
    tick(); // e2
    checks++; if (vin !== 15'd100) begin errors++; $display("FAIL rst_lost_data_vin got=%0d want=100", $signed(vin)); end
`ifdef DSM_SAMPLE_CTRL_DITHER_EN
    exp_dith = 10'd1;
`else
    exp_dith = 10'd0;
`endif
    checks++; if (dith !== exp_dith) begin errors++; $display("FAIL rst_e2_dith got=%0d want=%0d", $signed(dith), $signed(exp_dith)); end
    ticks(12); // e14, first RUN-sampled dither
    l = 16'hACE1;
    for (int i = 0; i < 12; i++) l = lfsr_next(l);
`ifdef DSM_SAMPLE_CTRL_DITHER_EN
    exp_dith = {{6{l[3]}}, l[3:0]};
`else
    exp_dith = 10'd0;
`endif
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL rst_run_state got=%0d want=2", state); end
    checks++; if (dith !== exp_dith) begin errors++; $display("FAIL rst_run_dith got=%0d want=%0d", $signed(dith), $signed(exp_dith)); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_full_scale();
    test_underrun();
    test_drain_from_run();
    test_drain_from_ramp();
    test_fill_full();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dsm_sample_ctrl.md
# dsm_sample_ctrl

Sample scheduler and sequencer for the delta-sigma modulator datapath. It accepts PCM samples over a valid/ready stream into a small FIFO and presents each one to the modulator's `vin` input for exactly `OSR` modulator clocks. It owns the modulator's reset, and applies a soft-start/soft-stop gain ramp so enabling or disabling never steps the loop input. It also generates the dither word for the modulator's `dith_i` input.

## Interface
- `T_BITS`, 15: sample and modulator input width, two's complement.
- `OSR`, 64: modulator clocks per input sample; minimum 2.
- `FIFO_DEPTH`, 4: sample FIFO entries; power of two.
- `RAMP_SHIFT`, 4: gain ramp resolution; full-scale gain is 2^RAMP_SHIFT.

- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level request: 1 = run, 0 = stop.
- `clr_underrun`  in  1  synchronous clear of `underrun`.
- `s_valid`  in  1  upstream sample valid.
- `s_data`  in  `T_BITS`  upstream sample, signed.
- `s_ready`  out  1  FIFO can accept a sample.
- `vin`  out  `T_BITS`  to modulator `vin`, signed, registered.
- `dith`  out  `T_BITS`-5  to modulator `dith_i[T_BITS-1:5]`, signed, registered.
- `dsm_reset`  out  1  active-high synchronous reset to the modulator, registered.
- `state`  out  2  0=IDLE, 1=RAMP, 2=RUN, 3=DRAIN.
- `underrun`  out  1  sticky: a sample was needed in RAMP/RUN while the FIFO was empty.

## Operation
- FIFO: `s_ready` = !full && state != DRAIN. A push occurs on `s_valid && s_ready`. Push and pop in the same cycle leave the count unchanged. Data is never dropped or overwritten.
- Tick counter runs 0..OSR-1 while in RAMP/RUN/DRAIN and wraps to 0. It is held at 0 in IDLE.
- Fetch event occurs on the IDLE->RAMP transition, and on tick == OSR-1 in RAMP/RUN/DRAIN.
  - At a fetch with the FIFO non-empty: pop the head into `held`.
  - At a fetch with the FIFO empty: keep `held`. In RAMP/RUN, also set `underrun`.
- Gain register is RAMP_SHIFT+1 bits and is updated only at fetch events.
  - IDLE->RAMP: gain = 1.
  - RAMP: gain +1. When gain becomes 2^RAMP_SHIFT, go to RUN.
  - DRAIN: gain -1. When gain becomes 0, go to IDLE.
- State transitions:
  - IDLE: go to RAMP when `enable` = 1.
  - RAMP/RUN: go to DRAIN when `enable` = 0. In RAMP this happens immediately, from the current gain.
  - DRAIN: go to RAMP when `enable` = 1, with no gain reset; ramping resumes from the current gain at the next fetch. Go to IDLE when gain reaches 0.
  - Entering IDLE flushes the FIFO and clears `held`.
- Arithmetic:
  - `vin` = (held × gain) >>> RAMP_SHIFT, using a signed product of T_BITS+RAMP_SHIFT+1 bits and an arithmetic shift (rounds toward −inf).
  - At full gain, `vin` == `held` exactly. No saturation is needed.
- `dsm_reset` = 1 in IDLE and 0 otherwise.
- `underrun` is cleared by `clr_underrun`. A simultaneous set and clear resolves to set.

## Timing
- Reset values: `vin`=0, `dith`=0, `dsm_reset`=1, `state`=0, `underrun`=0, FIFO empty, gain=0, LFSR=16'hACE1. `s_ready`=1 after release.
- All outputs except `s_ready` are registered.
- `vin` reflects `held`/gain one clock after the fetch edge.
- After `enable` rises in IDLE:
  - `state`=1 and `dsm_reset`=0 at edge +1.
  - First scaled sample on `vin` at edge +2.
- The ramp lasts 2^RAMP_SHIFT−1 sample periods after the first fetch. The drain from full gain lasts 2^RAMP_SHIFT sample periods.
- `reset_n` low mid-operation forces reset values immediately; pending FIFO data is lost.

## Configuration
- `DSM_SAMPLE_CTRL_DITHER_EN` defined:
  - 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1.
  - Advances every clock outside IDLE.
  - `dith` = sign-extended lfsr[3:0], range −8..+7.
  - `dith` is 0 in IDLE.
- Not defined: no LFSR; `dith` is constant 0.

## Test plan
- Reset, prefill 3 samples (1000, 2000, 3000), raise `enable` with OSR=4, RAMP_SHIFT=2 -> `dsm_reset` falls at edge +1; `vin` = 250, then 1000, then 2250 (gain 1/4, 2/4, 3/4); `state`=2 when gain reaches 4.
- In RUN, push −16384 -> `vin` = −16384 for exactly OSR clocks; no overflow.
- FIFO empty at a RUN fetch -> `vin` holds the last value and `underrun`=1. Assert `clr_underrun` together with a new underrun -> `underrun` stays 1.
- Drop `enable` during RAMP at gain 2 -> DRAIN; gain 1, then 0; IDLE; `dsm_reset`=1; FIFO flushed; `s_ready`=0 throughout DRAIN.
- Fill 4 samples with `s_valid` held high -> `s_ready`=0 when full, and the 5th sample is accepted only after a pop.
- Pulse `reset_n` low mid-RUN -> all outputs at reset values asynchronously. With DITHER_EN, the first RUN `dith` after restart matches the LFSR sequence from 16'hACE1.
